// File: rtl/fp_norm_arbiter.sv
// Round-robin arbiter for a shared pipelined FP normaliser. It tags each issued op with its
// requester ID, returns registered ID-tagged results and bounds outstanding ops per requester.
module fp_norm_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 1,
    parameter int MAX_OUT = 2,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(MAX_OUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_sign,
    input  logic [7*NUM_REQ-1:0]    req_exponent,
    input  logic [18*NUM_REQ-1:0]   req_mantissa,
    input  logic [NUM_REQ-1:0]      req_is_cvtfr,
    input  logic                    hold,
    output logic                    norm_sign,
    output logic [6:0]              norm_exponent,
    output logic [17:0]             norm_mantissa,
    output logic                    norm_is_cvtfr,
    input  logic                    unit_sign,
    input  logic [6:0]              unit_exponent,
    input  logic [16:0]             unit_mantissa,
    output logic                    rsp_valid,
    output logic [IW-1:0]           rsp_id,
    output logic                    rsp_sign,
    output logic [6:0]              rsp_exponent,
    output logic [16:0]             rsp_mantissa,
    output logic                    busy
);

    logic [IW-1:0]                ptr_r;
    logic [NUM_REQ-1:0][CW-1:0]   cnt_r;
    logic [LATENCY-1:0]           tag_v_r;
    logic [LATENCY-1:0][IW-1:0]   tag_id_r;
    logic                         rsp_valid_r;
    logic [IW-1:0]                rsp_id_r;
    logic                         rsp_sign_r;
    logic [6:0]                   rsp_exponent_r;
    logic [16:0]                  rsp_mantissa_r;

    logic [NUM_REQ-1:0]           elig_s;
    logic [NUM_REQ-1:0]           inc_s;
    logic [NUM_REQ-1:0]           dec_s;
    logic                         grant_s;
    logic [IW-1:0]                winner_s;

    // Eligibility uses registered credits only; a same-cycle response does not free a slot.
    always_comb begin
        elig_s = '0;
        inc_s  = '0;
        dec_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i] = req_valid[i] && !hold && rst_n && (cnt_r[i] < CW'(MAX_OUT));
            inc_s[i]  = grant_s && (winner_s == IW'(i));
            dec_s[i]  = rsp_valid_r && (rsp_id_r == IW'(i));
        end
    end

    // Round-robin search starting at ptr_r; first eligible index wins.
    always_comb begin
        int idx;
        grant_s  = 1'b0;
        winner_s = '0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!grant_s && elig_s[idx]) begin
                grant_s  = 1'b1;
                winner_s = IW'(idx);
            end else begin
                grant_s  = grant_s;
            end
        end
    end

    // Grant vector and operand mux; a non-grant cycle issues an all-zero bubble.
    always_comb begin
        req_ready     = '0;
        norm_sign     = 1'b0;
        norm_exponent = 7'd0;
        norm_mantissa = 18'd0;
        norm_is_cvtfr = 1'b0;
        if (grant_s) begin
            req_ready[winner_s] = 1'b1;
            norm_sign     = req_sign[winner_s];
            norm_exponent = req_exponent[int'(winner_s)*7 +: 7];
            norm_mantissa = req_mantissa[int'(winner_s)*18 +: 18];
            norm_is_cvtfr = req_is_cvtfr[winner_s];
        end else begin
            req_ready = '0;
        end
    end

    // Pointer, credits, tag pipe and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r          <= '0;
            cnt_r          <= '0;
            tag_v_r        <= '0;
            tag_id_r       <= '0;
            rsp_valid_r    <= 1'b0;
            rsp_id_r       <= '0;
            rsp_sign_r     <= 1'b0;
            rsp_exponent_r <= 7'd0;
            rsp_mantissa_r <= 17'd0;
        end else begin
            if (grant_s) begin
                ptr_r <= (winner_s == IW'(NUM_REQ - 1)) ? IW'(0) : winner_s + IW'(1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({inc_s[i], dec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
            for (int s = LATENCY - 1; s > 0; s--) begin
                tag_v_r[s]  <= tag_v_r[s-1];
                tag_id_r[s] <= tag_id_r[s-1];
            end
            tag_v_r[0]  <= grant_s;
            tag_id_r[0] <= winner_s;
            if (tag_v_r[LATENCY-1]) begin
                rsp_valid_r    <= 1'b1;
                rsp_id_r       <= tag_id_r[LATENCY-1];
                rsp_sign_r     <= unit_sign;
                rsp_exponent_r <= unit_exponent;
                rsp_mantissa_r <= unit_mantissa;
            end else begin
                rsp_valid_r    <= 1'b0;
            end
        end
    end

    assign rsp_valid    = rsp_valid_r;
    assign rsp_id       = rsp_id_r;
    assign rsp_sign     = rsp_sign_r;
    assign rsp_exponent = rsp_exponent_r;
    assign rsp_mantissa = rsp_mantissa_r;
    assign busy         = (|tag_v_r) || rsp_valid_r;

    fp_norm_arbiter_chk #(.NUM_REQ(NUM_REQ), .MAX_OUT(MAX_OUT), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt_r),
        .inc   (inc_s),
        .dec   (dec_s)
    );

endmodule

// Credit-counter bounds: no underflow on a response, no overflow on a grant.
module fp_norm_arbiter_chk #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 2,
    parameter int CW      = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic [NUM_REQ-1:0][CW-1:0] cnt,
    input logic [NUM_REQ-1:0]      inc,
    input logic [NUM_REQ-1:0]      dec
);
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
        a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            (dec[i] && !inc[i]) |-> (cnt[i] != CW'(0)));
        a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            (inc[i] && !dec[i]) |-> (cnt[i] < CW'(MAX_OUT)));
    end
endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Scoreboard bench for fp_norm_arbiter: a reference arbiter/credit model predicts grants,
// expected results are queued at issue and compared when the response bus fires.
module tb_fp_norm_arbiter;
    localparam int NR  = 4;
    localparam int LAT = 4;
    localparam int MO  = 2;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_sign;
    logic [7*NR-1:0] req_exponent;
    logic [18*NR-1:0] req_mantissa;
    logic [NR-1:0]   req_is_cvtfr;
    logic            hold;
    logic            norm_sign;
    logic [6:0]      norm_exponent;
    logic [17:0]     norm_mantissa;
    logic            norm_is_cvtfr;
    logic            unit_sign;
    logic [6:0]      unit_exponent;
    logic [16:0]     unit_mantissa;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic            rsp_sign;
    logic [6:0]      rsp_exponent;
    logic [16:0]     rsp_mantissa;
    logic            busy;

    fp_norm_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .MAX_OUT(MO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_sign(req_sign), .req_exponent(req_exponent), .req_mantissa(req_mantissa),
        .req_is_cvtfr(req_is_cvtfr), .hold(hold),
        .norm_sign(norm_sign), .norm_exponent(norm_exponent), .norm_mantissa(norm_mantissa),
        .norm_is_cvtfr(norm_is_cvtfr),
        .unit_sign(unit_sign), .unit_exponent(unit_exponent), .unit_mantissa(unit_mantissa),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sign(rsp_sign),
        .rsp_exponent(rsp_exponent), .rsp_mantissa(rsp_mantissa), .busy(busy)
    );

    always #5 clk = ~clk;

    // Leading-one normalise: exponent += position of leading one, hidden bit dropped.
    function automatic logic [24:0] nfn(input logic s, input logic [6:0] e, input logic [17:0] m);
        int p;
        logic [17:0] sh;
        p = -1;
        for (int b = 0; b < 18; b++) if (m[b]) p = b;
        if (p < 0) return {s, 7'd0, 17'd0};
        sh = m << (17 - p);
        return {s, 7'(int'(e) + p), sh[16:0]};
    endfunction

    // Environment normaliser: LAT-deep pipeline fed from the norm_* bus.
    logic [24:0] upipe [LAT];
    always @(posedge clk) begin
        upipe[0] <= nfn(norm_sign, norm_exponent, norm_mantissa);
        for (int s = 1; s < LAT; s++) upipe[s] <= upipe[s-1];
    end
    assign {unit_sign, unit_exponent, unit_mantissa} = upipe[LAT-1];

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [24:0] res;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ptr_m = 0;
    int   cnt_m [NR];
    bit   was_rst = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock of stimulus plus model update and all per-cycle comparisons.
    task automatic step(input logic [NR-1:0] vmask, input logic h, input logic rn, input bit fix);
        int win;
        bit hit;
        logic [1:0] rid;
        logic [7:0] cm;
        exp_t e;
        @(negedge clk);
        rst_n        = rn;
        hold         = h;
        req_valid    = vmask;
        req_sign     = NR'($urandom);
        req_exponent = (7*NR)'($urandom);
        req_mantissa = (18*NR)'({$urandom, $urandom, $urandom});
        req_is_cvtfr = NR'($urandom);
        if (fix) begin
            req_sign[2]          = 1'b0;
            req_exponent[20:14]  = 7'd63;
            req_mantissa[53:36]  = 18'h20000;
            req_is_cvtfr[2]      = 1'b0;
        end
        #1;
        if (!rn) begin
            check_eq("rst_ready", 64'(req_ready), 64'd0);
            check_eq("rst_norm", 64'({norm_sign, norm_exponent, norm_mantissa, norm_is_cvtfr}), 64'd0);
            sb.delete();
            for (int i = 0; i < NR; i++) cnt_m[i] = 0;
            ptr_m   = 0;
            was_rst = 1'b1;
            cyc++;
            return;
        end
        if (was_rst) begin
            check_eq("rst_rsp_fields", 64'({rsp_id, rsp_sign, rsp_exponent, rsp_mantissa}), 64'd0);
            was_rst = 1'b0;
        end
        check_eq("busy", 64'(busy), 64'(sb.size() > 0));
        for (int i = 0; i < NR; i++) cm[i*2 +: 2] = 2'(cnt_m[i]);
        check_eq("cnt", 64'(dut.cnt_r), 64'(cm));
        hit = 1'b0;
        rid = 2'd0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("rsp_id", 64'(rsp_id), 64'(e.id));
            check_eq("rsp_data", 64'({rsp_sign, rsp_exponent, rsp_mantissa}), 64'(e.res));
            hit = 1'b1;
            rid = e.id;
        end else begin
            check_eq("rsp_idle", 64'(rsp_valid), 64'd0);
        end
        win = -1;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (ptr_m + k) % NR;
            if (win < 0 && vmask[idx] && !h && cnt_m[idx] < MO) win = idx;
        end
        check_eq("ready", 64'(req_ready), (win >= 0) ? (64'd1 << win) : 64'd0);
        if (win >= 0) begin
            check_eq("norm", 64'({norm_sign, norm_exponent, norm_mantissa, norm_is_cvtfr}),
                     64'({req_sign[win], req_exponent[win*7 +: 7], req_mantissa[win*18 +: 18], req_is_cvtfr[win]}));
            e.due = cyc + LAT + 1;
            e.id  = 2'(win);
            e.res = nfn(req_sign[win], req_exponent[win*7 +: 7], req_mantissa[win*18 +: 18]);
            sb.push_back(e);
            cnt_m[win]++;
            ptr_m = (win + 1) % NR;
        end else begin
            check_eq("bubble", 64'({norm_sign, norm_exponent, norm_mantissa, norm_is_cvtfr}), 64'd0);
        end
        if (hit) cnt_m[rid]--;
        cyc++;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; hold = 1'b0; req_valid = '0;
        req_sign = '0; req_exponent = '0; req_mantissa = '0; req_is_cvtfr = '0;
        for (int i = 0; i < NR; i++) cnt_m[i] = 0;
        // Reset with requests present: nothing may be granted.
        repeat (3) step(4'b1111, 1'b0, 1'b0, 1'b0);
        // Single op from requester 2 with a known operand.
        step(4'b0100, 1'b0, 1'b1, 1'b1);
        repeat (8) step(4'b0000, 1'b0, 1'b1, 1'b0);
        // Round-robin with all requesters valid until credits bind.
        repeat (24) step(4'b1111, 1'b0, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b0, 1'b1, 1'b0);
        // Credit limit: requester 1 alone.
        repeat (16) step(4'b0010, 1'b0, 1'b1, 1'b0);
        repeat (8) step(4'b0000, 1'b0, 1'b1, 1'b0);
        // Hold mid-stream, then release: pointer must resume where it stopped.
        repeat (3) step(4'b1111, 1'b0, 1'b1, 1'b0);
        repeat (10) step(4'b1111, 1'b1, 1'b1, 1'b0);
        repeat (6) step(4'b1011, 1'b0, 1'b1, 1'b0);
        // Reset with ops in flight.
        repeat (4) step(4'b1111, 1'b0, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        repeat (4) step(4'b0110, 1'b0, 1'b1, 1'b0);
        // Random masks and holds.
        repeat (300) step(NR'($urandom), ($urandom_range(0, 7) == 0), 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b0, 1'b1, 1'b0);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
